shift_add_mult_n: RTL and testbench

SHIFT_ADD_MULT_N -- requirements
Module: shift_add_mult_n

---
 rtl/shift_add_mult_n.sv | 93 +++++++++
 tb/tb_shift_add_mult_n.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_n.sv
// rtl/shift_add_mult_n.sv - sequential shift-and-add unsigned multiplier (optional MULT_ZERO_SKIP_EN)
`timescale 1ns/1ps
module shift_add_mult_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] q_nx;

    // Carry-out lands in the accumulator MSB after the shift, so nothing is lost.
    always_comb begin
        addend   = q_r[0] ? b_r : '0;
        sum_full = {1'b0, acc_r} + {1'b0, addend};
        acc_nx   = sum_full[WIDTH:1];
        q_nx     = {sum_full[0], q_r[WIDTH-1:1]};
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            q_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_r   <= a_in;
                        b_r   <= b_in;
                        acc_r <= '0;
                        count <= '0;
`ifdef MULT_ZERO_SKIP_EN
                        if ((a_in == '0) || (b_in == '0)) begin
                            state   <= DONE;
                            product <= '0;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc_r <= acc_nx;
                    q_r   <= q_nx;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state   <= DONE;
                        product <= {acc_nx, q_nx};
                    end
                end
                DONE: begin
                    // done is registered so it lines up with the held product one edge later
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_n.sv
// tb/tb_shift_add_mult_n.sv - self-checking bench for shift_add_mult_n
`timescale 1ns/1ps
module tb_shift_add_mult_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [31:0] product16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_add_mult_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .product(product)
    );

    shift_add_mult_n #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16),
        .busy(busy16), .done(done16), .product(product16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return 1;
`endif
        return 9;
    endfunction

    function automatic int exp_busy(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return 0;
`endif
        return 8;
    endfunction

    // Observe 16 sample points after the acceptance edge (index n = edges after acceptance).
    task automatic watch8(output logic [15:0] prod, output int lat, output int nbusy,
                          output int ndone, output int overlap);
        lat = -1; nbusy = 0; ndone = 0; overlap = 0; prod = '0;
        for (int n = 0; n < 16; n++) begin
            if (busy) nbusy++;
            if (busy && done) overlap++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat  = n;
                    prod = product;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [15:0] prod;
        int lat, nbusy, ndone, overlap;
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        watch8(prod, lat, nbusy, ndone, overlap);
        check({tag, " product"}, 64'(prod), 64'(32'(a) * 32'(b)));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat(a, b)));
        check({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_busy(a, b)));
        check({tag, " done_pulses"}, 64'(ndone), 64'd1);
        check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, " product_held"}, 64'(product), 64'(32'(a) * 32'(b)));
    endtask

    initial begin
        logic [15:0] prod;
        int lat, nbusy, ndone, overlap;
        logic [7:0] ra, rb;
        int got1, acc_n, lat1, lat2;
        logic [31:0] p1, p2;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd77,  16'h0000};
        vecs[3] = '{8'd1,   8'd255, 16'h00FF};
        vecs[4] = '{8'd128, 8'd2,   16'h0100};
        vecs[5] = '{8'd255, 8'd1,   16'h00FF};
        vecs[6] = '{8'd77,  8'd0,   16'h0000};
        vecs[7] = '{8'd170, 8'd85,  16'h3872};

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset product", 64'(product), 64'd0);
        check("reset product16", 64'(product16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), 64'(product), 64'(vecs[i].p));
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run8(ra, rb, $sformatf("rand%0d", i));
        end

        // start re-pulsed mid-RUN must be ignored
        @(negedge clk);
        a_in = 8'd3; b_in = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; ndone = 0; prod = '0;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = n; prod = product; end
            end
            if (n == 3) begin start = 1'b1; a_in = 8'd7; b_in = 8'd7; end
            if (n == 4) start = 1'b0;
            @(posedge clk); #1;
        end
        check("restart product", 64'(prod), 64'h000F);
        check("restart done_pulses", 64'(ndone), 64'd1);
        check("restart latency", 64'(lat), 64'd9);

        // reset mid-RUN aborts with no done
        @(negedge clk);
        a_in = 8'd200; b_in = 8'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort product", 64'(product), 64'd0);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
            if (n == 2) rst_n = 1'b1;
        end
        check("abort no_activity", 64'(ndone), 64'd0);
        check("abort product_stays", 64'(product), 64'd0);

        // release reset with start already high: accepted on the first edge
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; a_in = 8'd6; b_in = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        watch8(prod, lat, nbusy, ndone, overlap);
        check("post_reset product", 64'(prod), 64'h002A);
        check("post_reset latency", 64'(lat), 64'd9);
        check("post_reset done_pulses", 64'(ndone), 64'd1);

        // 16-bit back-to-back
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        got1 = 0; acc_n = -1; lat1 = -1; lat2 = -1; p1 = '0; p2 = '0;
        for (int n = 0; n < 60; n++) begin
            if (start16) begin
                start16 = 1'b0;
                acc_n = n;
            end
            if (done16 && got1 == 0) begin
                got1 = 1; lat1 = n; p1 = product16;
                start16 = 1'b1; a16 = 16'h1234; b16 = 16'h0010;
            end else if (done16 && got1 == 1 && acc_n >= 0) begin
                got1 = 2; lat2 = n - acc_n; p2 = product16;
            end
            @(posedge clk); #1;
        end
        check("w16 first product", 64'(p1), 64'h0001FFFE);
        check("w16 first latency", 64'(lat1), 64'd17);
        check("w16 second product", 64'(p2), 64'h00012340);
        check("w16 second latency", 64'(lat2), 64'd17);
        check("w16 throughput", 64'(acc_n), 64'd18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
